// File: rtl/tcdm_bank_arb.sv
// tcdm_bank_arb
// Arbitrates NumMaster initiators onto one single-ported TCDM bank and
// routes the bank's one-cycle-latency response back to the granted initiator.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   arb_policy_i           0 = round-robin, 1 = fixed priority (lowest index)
//   req_i/add_i/wen_i/
//   wdata_i/be_i           per-initiator request fields
//   gnt_o                  one-hot grant (combinational, follows gnt_i)
//   vld_o/rdata_o          per-initiator response, one cycle after handshake
//   req_o/add_o/wen_o/
//   wdata_o/be_o, gnt_i    bank request side
//   rdata_i                bank read data
//   cnt_clr_i              clears the conflict counter
//   conflict_cnt_o         cycles with two or more simultaneous requests
//
// Build option: define TCDM_BANK_ARB_PERF_EN to instantiate the saturating
// conflict counter; otherwise conflict_cnt_o is tied to zero.

module tcdm_bank_arb #(
  parameter int unsigned NumMaster    = 8,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    arb_policy_i,
  input  logic [NumMaster-1:0]                    req_i,
  input  logic [NumMaster-1:0][AddrMemWidth-1:0]  add_i,
  input  logic [NumMaster-1:0]                    wen_i,
  input  logic [NumMaster-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumMaster-1:0][BeWidth-1:0]       be_i,
  output logic [NumMaster-1:0]                    gnt_o,
  output logic [NumMaster-1:0]                    vld_o,
  output logic [NumMaster-1:0][DataWidth-1:0]     rdata_o,
  output logic                                    req_o,
  input  logic                                    gnt_i,
  output logic [AddrMemWidth-1:0]                 add_o,
  output logic                                    wen_o,
  output logic [DataWidth-1:0]                    wdata_o,
  output logic [BeWidth-1:0]                      be_o,
  input  logic [DataWidth-1:0]                    rdata_i,
  input  logic                                    cnt_clr_i,
  output logic [CntWidth-1:0]                     conflict_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumMaster);

  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      rr_idx, fp_idx, win_idx;
  logic                 rr_found;
  logic                 hs;
  logic                 vld_q;
  logic [NumMaster-1:0] id_q;

  // Round-robin: first requester at or above ptr_q, wrapping to 0.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NumMaster; i++) begin
      if (!rr_found && req_i[(int'(ptr_q) + i) % NumMaster]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'((int'(ptr_q) + i) % NumMaster);
      end
    end
  end

  // Fixed priority: lowest requesting index wins (scan downward, last hit sticks).
  always_comb begin
    fp_idx = '0;
    for (int i = NumMaster - 1; i >= 0; i--) begin
      if (req_i[i]) fp_idx = IdxW'(i);
    end
  end

  assign win_idx = arb_policy_i ? fp_idx : rr_idx;
  assign req_o   = |req_i;
  assign hs      = req_o & gnt_i;

  assign add_o   = add_i[win_idx];
  assign wen_o   = wen_i[win_idx];
  assign wdata_o = wdata_i[win_idx];
  assign be_o    = be_i[win_idx];

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NumMaster; k++) begin
      gnt_o[k] = hs && (win_idx == IdxW'(k));
    end
  end

  // Pointer only moves on a completed round-robin handshake; stalls and
  // fixed-priority cycles leave it where it was.
  always_comb begin
    ptr_d = ptr_q;
    if (hs && !arb_policy_i) begin
      ptr_d = (win_idx == IdxW'(NumMaster - 1)) ? '0 : win_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      vld_q <= 1'b0;
      id_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= hs;
      id_q  <= gnt_o;
    end
  end

  assign vld_o = vld_q ? id_q : '0;

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NumMaster; k++) begin
      rdata_o[k] = rdata_i;
    end
  end

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                multi_req;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = |(req_i & (req_i - NumMaster'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (multi_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign conflict_cnt_o = '0;
`endif

endmodule
